// File: rtl/demux1_2_3_stream_pkg.sv
// ---------------------------------------------------------------------------
// demux1_2_3_stream_pkg
// Shared definitions for the streaming 1-to-2 demultiplexer:
//   DEFAULT_WIDTH : default beat width
//   DEST_OUT0/1   : values of in_sel that pick each output stream
//   count_width() : width needed to hold an occupancy of 0..depth
// ---------------------------------------------------------------------------
package demux1_2_3_stream_pkg;

    localparam int   DEFAULT_WIDTH = 3;
    localparam logic DEST_OUT0     = 1'b0;
    localparam logic DEST_OUT1     = 1'b1;

    // An occupancy counter must represent the full state (== depth), hence +1.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/demux1_2_3_stream_fifo.sv
// ---------------------------------------------------------------------------
// demux_fifo_3
// Single-clock FIFO used once per output of the demultiplexer.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_data : write request and payload (ignored when full)
//   pop             : consumer ready (ignored when empty)
//   valid, data     : head of queue; data reads 0 while empty
//   count           : current occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module demux_fifo_3
    import demux1_2_3_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 2,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Full/empty come only from the counter; pointers are allowed to alias.
    assign full    = (count == CW'(DEPTH));
    assign valid   = (count != '0);
    assign do_push = push && !full;
    assign do_pop  = pop && valid;

    // Head is masked so an empty queue never exposes stale storage.
    assign data = valid ? mem[rd_ptr] : '0;

    // Storage needs no reset: it is only ever read behind a nonzero count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux1_2_3_stream.sv
// ---------------------------------------------------------------------------
// demux1_2_3_stream
// Routes one producer stream to one of two consumer streams by in_sel, with
// a small FIFO per output so a stalled consumer only blocks its own beats.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data      : producer handshake and payload
//   in_sel                         : destination (DEST_OUT0 / DEST_OUT1)
//   out0_valid/out0_ready/out0_data: consumer 0 stream
//   out1_valid/out1_ready/out1_data: consumer 1 stream
//   cnt0, cnt1                     : per-output FIFO occupancy
// ---------------------------------------------------------------------------
module demux1_2_3_stream
    import demux1_2_3_stream_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = 2,
    parameter int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CW-1:0]    cnt0,
    output logic [CW-1:0]    cnt1
);

    logic push0;
    logic push1;

    // Ready looks only at the registered count of the selected queue, so
    // there is no combinational path from either consumer's ready.
    assign in_ready = ((in_sel == DEST_OUT1) ? cnt1 : cnt0) < CW'(DEPTH);

    assign push0 = in_valid && in_ready && (in_sel == DEST_OUT0);
    assign push1 = in_valid && in_ready && (in_sel == DEST_OUT1);

    demux_fifo_3 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (in_data),
        .pop       (out0_ready),
        .valid     (out0_valid),
        .data      (out0_data),
        .count     (cnt0)
    );

    demux_fifo_3 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (in_data),
        .pop       (out1_ready),
        .valid     (out1_valid),
        .data      (out1_data),
        .count     (cnt1)
    );

    // A producer that has raised valid must hold its beat until accepted.
    property p_in_hold;
        @(posedge clk) disable iff (rst)
            (in_valid && !in_ready) |=> (in_valid && $stable(in_data) && $stable(in_sel));
    endproperty
    a_in_hold: assert property (p_in_hold);

    // Each output head stays put until the consumer takes it.
    property p_out0_hold;
        @(posedge clk) disable iff (rst)
            (out0_valid && !out0_ready) |=> (out0_valid && $stable(out0_data));
    endproperty
    a_out0_hold: assert property (p_out0_hold);

    property p_out1_hold;
        @(posedge clk) disable iff (rst)
            (out1_valid && !out1_ready) |=> (out1_valid && $stable(out1_data));
    endproperty
    a_out1_hold: assert property (p_out1_hold);

endmodule

// File: doc/demux1_2_3_stream.md
Name: demux1_2_3_stream

Overview:
- Streaming 1-to-2 demultiplexer; the inverse of the datapath 2:1 selector.
- A single WIDTH-bit producer stream is routed to one of two consumer streams by a per-beat select bit.
- Each output has a small FIFO, so one stalled consumer does not block beats bound for the other while that output's FIFO has room.
- Sits between a shared result bus and two downstream consumers, e.g. writeback and debug/trace capture.

Parameters:
- WIDTH, 3, data width of each beat.
- DEPTH, 2, entries per output FIFO; power of 2, minimum 2.
- CW, $clog2(DEPTH+1), width of the occupancy counters (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer beat valid.
- in_ready  output  1  beat accepted this cycle when in_valid && in_ready.
- in_data  input  WIDTH  beat payload.
- in_sel  input  1  destination: 0 selects out0, 1 selects out1.
- out0_valid  output  1  out0 head valid.
- out0_ready  input  1  consumer 0 accepts.
- out0_data  output  WIDTH  out0 head payload.
- out1_valid  output  1  out1 head valid.
- out1_ready  input  1  consumer 1 accepts.
- out1_data  output  WIDTH  out1 head payload.
- cnt0  output  CW  out0 FIFO occupancy.
- cnt1  output  CW  out1 FIFO occupancy.

Behaviour:
- Reset (asynchronous, on rst high):
  - Read/write pointers and counts go to 0.
  - out0_valid = out1_valid = 0; out0_data = out1_data = 0; cnt0 = cnt1 = 0.
  - Storage contents are don't-care, but data outputs must read 0 while empty.
- in_ready = (in_sel ? cnt1 : cnt0) < DEPTH.
  - Combinational on in_sel and registered counts only.
  - No path from out*_ready to in_ready; no pop-through when full.
- Push: when in_valid && in_ready at a clock edge, in_data is written to FIFO[in_sel] at its write pointer. The write pointer increments modulo DEPTH.
- Pop: when outN_valid && outN_ready at a clock edge, the FIFO N read pointer increments modulo DEPTH.
- Output view:
  - outN_valid = (cntN != 0).
  - outN_data = storage[rd_ptr] when valid, else 0.
- Latency: a beat accepted at edge k is presented on its output from edge k onward (visible in cycle k+1). There is no same-cycle bypass.
- Counters:
  - cntN += 1 on push only; -= 1 on pop only; unchanged on simultaneous push+pop.
  - Simultaneous push+pop is legal for a FIFO that is neither empty nor full. It is also legal when full, but in that case the push is blocked by in_ready, so only the pop occurs.
- Ordering: FIFO order is preserved per output. Nothing is promised about relative order across the two outputs.
- in_valid low: in_sel and in_data are ignored and no state changes.
- Protocol assumptions on the producer (checked by assertions, not by RTL):
  - Once in_valid is high, in_data and in_sel are held until accepted.
- Protocol guarantees on the outputs:
  - Once outN_valid is high, outN_data is held until popped.
- Head-of-line: if the selected FIFO is full, the input stalls even when the other FIFO has space. The producer must not reorder to get around this.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty is determined from cntN, never from pointer equality.
- Reset mid-transfer: all queued beats are discarded and both outputs drop valid asynchronously.

Decomposition:
- Shared package: the WIDTH default, the DEST_OUT0/DEST_OUT1 select constants, and a $clog2-based count-width helper.
- One natural sub-module, demux_fifo_3:
  - Single-clock FIFO with WIDTH/DEPTH parameters, push/pop, valid/data head, and count.
  - Instantiated twice.
- The top level holds only the in_ready selection and the push steering.

Test Plan:
- Reset: assert rst mid-stream with 2 beats queued in out0 -> out0_valid=0, cnt0=0, out0_data=0 immediately, without waiting for a clock edge.
- Basic routing: push 3'd5 with sel=0, then 3'd2 with sel=1, both consumers ready -> out0 shows 5 and out1 shows 2, each one cycle after its acceptance edge; counts return to 0.
- Fill and stall: out0_ready=0; push 1, 4, 6 with sel=0 -> first two accepted (cnt0=2), in_ready=0 on the third; raise out0_ready -> out0 yields 1, 4, then 6 after it is accepted.
- Independence: out0 full with out0_ready=0; push 3'd7 with sel=1 -> in_ready=1, out1 receives 7, cnt0 stays 2.
- Simultaneous push+pop: cnt1=1, out1_ready=1, push 3'd3 with sel=1 -> cnt1 stays 1, the old head pops, and 3 becomes the head next cycle.
- Wrap-around: stream 8 beats 0..7 to out0 with out0_ready toggling every cycle -> values emerge in order 0..7, pointers wrap, and cnt0 never exceeds 2.
